spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Buffered front-end that sits directly upstream of the SPI master top-level. Accepts words from the host on a valid/ready stream into a TX FIFO, launches one SPI frame per word via single-cycle `spi_start` pulses, captures each received word on `spi_rx_valid` into an RX FIFO, and returns it on a second valid/ready stream. Only one frame is ever in flight. A watchdog aborts frames whose completion never arrives.

## Interface
Parameters:
- `WIDTH`, 8: frame width; must match the SPI master's `WIDTH`.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `TIMEOUT`, 1024: max cycles in WAIT before abort; ≥16.

Ports (`LW` = $clog2(DEPTH)+1):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the next `clk` edge).
- `s_valid`  in  1  host write request.
- `s_ready`  out  1  TX FIFO not full.
- `s_data`  in  WIDTH  word to transmit.
- `m_valid`  out  1  RX FIFO not empty.
- `m_ready`  in  1  host read acknowledge.
- `m_data`  out  WIDTH  RX FIFO head (show-ahead).
- `spi_start`  out  1  one-cycle launch pulse to the SPI master.
- `spi_tx_data`  out  WIDTH  frame data; stable from the `spi_start` cycle through the end of WAIT.
- `spi_rx_data`  in  WIDTH  received frame from the SPI master.
- `spi_rx_valid`  in  1  received frame strobe.
- `busy`  out  1  FSM not IDLE or TX FIFO non-empty.
- `tx_level`  out  LW  TX FIFO occupancy.
- `rx_level`  out  LW  RX FIFO occupancy.
- `timeout_err`  out  1  sticky abort flag.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- Push TX when `s_valid && s_ready`. Pop RX when `m_valid && m_ready`. `s_ready` and `m_valid` derive from registered counts only; there is no same-cycle pass-through.
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE -> LAUNCH when TX is non-empty and `rx_level < DEPTH`. On the same edge, pop TX into the `spi_tx_data` register.
- LAUNCH: `spi_start`=1 for exactly this cycle. -> WAIT unconditionally, and the watchdog counter is cleared.
- WAIT: if `spi_rx_valid`=1, push `spi_rx_data` into RX and -> IDLE. Otherwise, when the counter reaches TIMEOUT-1, set `timeout_err`, discard the frame and -> IDLE.
- `spi_rx_valid` in IDLE or LAUNCH is ignored; nothing is stored.
- RX space is checked before launch, so an RX overflow is impossible.
- `timeout_err`: set has priority over `err_clr` in the same cycle.
- Simultaneous RX push (from the FSM) and pop (from the host): both take effect and `rx_level` is unchanged. The same applies to TX push and pop.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are LW bits. Full means count==DEPTH; empty means count==0.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `spi_start`=0, `spi_tx_data`=0, `busy`=0, `tx_level`=0, `rx_level`=0, `timeout_err`=0. FSM is in IDLE and the watchdog counter is 0.
- Word accepted at edge N with the FSM in IDLE and RX not full:
  - `tx_level` updates after edge N.
  - FSM leaves IDLE at edge N+1; `spi_start`=1 in cycle N+1..N+2.
  - WAIT from edge N+2.
- `spi_rx_valid` sampled at edge M in WAIT: `m_valid`=1 and `rx_level` incremented after edge M. The next launch is at edge M+1 if TX is non-empty.
- Minimum spacing between `spi_start` pulses is 3 cycles plus the SPI frame time.
- Timeout: the abort edge is TIMEOUT cycles after WAIT entry. `timeout_err`=1 from that edge onward.
- Reset asserted mid-frame (any state): all state clears at that edge, and a late `spi_rx_valid` is ignored in IDLE.

## Structure
- Shared package `spi_pkg`: FSM state enum (IDLE, LAUNCH, WAIT) and the default `WIDTH`/`DEPTH` constants used by both this block and the SPI master.
- One sub-module, `spi_sync_fifo` (parameters WIDTH, DEPTH; show-ahead; push/pop/full/empty/level), instantiated twice for TX and RX.
- The FSM, watchdog counter and error flag live in the top level.

## Test plan
- Single word: push 0xA5 with a loopback model returning 0x3C after 20 cycles -> exactly one `spi_start` pulse, `spi_tx_data`=0xA5 during WAIT, `m_data`=0x3C, `m_valid` rises 1 cycle after `spi_rx_valid`.
- Burst fill: push 6 words with `DEPTH`=4 and `m_ready`=0 -> `s_ready` drops at `tx_level`=4. Launches stop once `rx_level`=4. Draining RX resumes launches, and all 6 words return in order.
- Simultaneous events: push TX and pop RX on the same edge as an FSM RX push -> levels stay consistent and there is no loss or duplication across 32 random words.
- Timeout: no `spi_rx_valid` with `TIMEOUT`=16 -> `timeout_err` sets 16 cycles after WAIT entry, the FSM returns to IDLE, the next word launches, and `err_clr` clears the flag.
- Stray strobe: `spi_rx_valid` pulsed in IDLE -> `rx_level` stays 0.
- Reset in WAIT: drive `rst`=0 for one cycle -> all outputs return to reset values. A late `spi_rx_valid` is ignored and `m_valid` stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and its buffered burst front-end.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 8;
    localparam int unsigned SPI_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; pushes when full and
// pops when empty are ignored.
module spi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // Head reads as zero when empty so the output is defined out of reset.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Buffered SPI front-end: TX FIFO -> one frame in flight -> RX FIFO, with a
// watchdog that abandons frames whose completion strobe never arrives.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = SPI_WIDTH,
    parameter int unsigned DEPTH   = SPI_DEPTH,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   spi_start,
    output logic [WIDTH-1:0]       spi_tx_data,
    input  logic [WIDTH-1:0]       spi_rx_data,
    input  logic                   spi_rx_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    spi_state_t       r_state;
    logic             r_spi_start;
    logic [WIDTH-1:0] r_spi_tx_data;
    logic [CW-1:0]    r_wdog;
    logic             r_timeout_err;

    logic [WIDTH-1:0] w_tx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_launch;
    logic             w_rx_push;
    logic             w_timeout_set;

    // RX room is checked before launch, so the completing frame always fits.
    assign w_launch      = (r_state == IDLE) && !w_tx_empty && !w_rx_full;
    assign w_rx_push     = (r_state == WAIT) && spi_rx_valid;
    assign w_timeout_set = (r_state == WAIT) && !spi_rx_valid
                           && (r_wdog == CW'(TIMEOUT - 1));

    spi_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (s_valid),
        .i_push_data (s_data),
        .i_pop       (w_launch),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_level     (tx_level)
    );

    spi_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rx_push),
        .i_push_data (spi_rx_data),
        .i_pop       (m_ready),
        .o_head      (m_data),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_level     (rx_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_spi_start   <= 1'b0;
            r_spi_tx_data <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state       <= LAUNCH;
                        r_spi_start   <= 1'b1;
                        r_spi_tx_data <= w_tx_head;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
                    r_wdog  <= '0;
                end
                WAIT: begin
                    if (spi_rx_valid || w_timeout_set) begin
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready     = !w_tx_full;
    assign m_valid     = !w_rx_empty;
    assign spi_start   = r_spi_start;
    assign spi_tx_data = r_spi_tx_data;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != IDLE) || !w_tx_empty;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Randomised bench for spi_burst_ctrl: a queue-based reference model of the
// front-end is compared against every output on every cycle.
module tb_spi_burst_ctrl;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam logic [7:0]  KEY     = 8'h99;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, m_ready, err_clr;
    logic [7:0] s_data;
    logic       s_ready, m_valid, spi_start, busy, timeout_err;
    logic [7:0] m_data, spi_tx_data, spi_rx_data;
    logic       spi_rx_valid;
    logic [2:0] tx_level, rx_level;

    // SPI slave stand-in plus an injector for stray strobes
    logic       resp_valid = 1'b0, inj_valid = 1'b0;
    logic [7:0] resp_data = 8'h00, inj_data = 8'h00;
    bit         resp_en = 1'b1, resp_rand = 1'b0;
    int         resp_lat = 20, pend = 0, starts = 0, cyc = 0, rx_cyc = 0;
    assign spi_rx_valid = resp_valid | inj_valid;
    assign spi_rx_data  = inj_valid ? inj_data : resp_data;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    spi_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .spi_start(spi_start),
        .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .busy(busy), .tx_level(tx_level), .rx_level(rx_level),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: queues for the FIFOs, frame age counted from launch edge
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         age = -1;
    logic [7:0] m_txd = 8'h00;
    bit         m_start = 1'b0, m_err = 1'b0;

    always @(posedge clk) begin
        int tx_n, rx_n;
        bit launch, rxp, abrt;
        if (!rst) begin
            tx_q.delete();
            rx_q.delete();
            age = -1;
            m_txd = 8'h00;
            m_start = 1'b0;
            m_err = 1'b0;
        end else begin
            tx_n   = tx_q.size();
            rx_n   = rx_q.size();
            launch = (age < 0) && (tx_n > 0) && (rx_n < DEPTH);
            rxp    = (age >= 1) && spi_rx_valid;
            abrt   = (age >= 1) && !spi_rx_valid && (age == TIMEOUT);
            if (launch) m_txd = tx_q.pop_front();
            if (s_valid && tx_n < DEPTH) tx_q.push_back(s_data);
            if (m_ready && rx_n > 0) void'(rx_q.pop_front());
            if (rxp) rx_q.push_back(spi_rx_data);
            m_start = launch;
            if (launch) age = 0;
            else if (rxp || abrt) age = -1;
            else if (age >= 0) age++;
            if (abrt) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", 32'(s_ready), 32'(tx_q.size() < DEPTH));
            chk("m_valid", 32'(m_valid), 32'(rx_q.size() > 0));
            if (rx_q.size() > 0) chk("m_data", 32'(m_data), 32'(rx_q[0]));
            chk("spi_start", 32'(spi_start), 32'(m_start));
            chk("spi_tx_data", 32'(spi_tx_data), 32'(m_txd));
            chk("busy", 32'(busy), 32'((age >= 0) || (tx_q.size() > 0)));
            chk("tx_level", 32'(tx_level), 32'(tx_q.size()));
            chk("rx_level", 32'(rx_level), 32'(rx_q.size()));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                resp_valid = 1'b1;
                resp_data  = spi_tx_data ^ KEY;
                rx_cyc     = cyc;
            end
        end
        if (spi_start === 1'b1) begin
            starts++;
            if (resp_en) pend = resp_rand ? int'($urandom_range(1, 6)) : resp_lat;
        end
    end

    task automatic push(input logic [7:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 400) begin
            tick(1);
            n++;
        end
        if (!s_ready) fail_to("push");
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_spi_start"}, 32'(spi_start), 32'd0);
        chk({tag, "_spi_tx_data"}, 32'(spi_tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx_level"}, 32'(tx_level), 32'd0);
        chk({tag, "_rx_level"}, 32'(rx_level), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic wait_mvalid(input string name, input int bound);
        int n = 0;
        while (!m_valid && n < bound) begin
            tick(1);
            n++;
        end
        if (!m_valid) fail_to(name);
    endtask

    task automatic wait_start(input string name, output int at);
        int n = 0;
        while (spi_start !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        at = cyc;
        if (spi_start !== 1'b1) fail_to(name);
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] sent[$];
        int base, t0, n;

        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0; err_clr = 1'b0;
        tick(3);
        rst = 1'b1;
        check_reset_vals("reset");
        chk_en = 1'b1;

        // single word through a 20-cycle loopback
        base = starts;
        push(8'hA5);
        wait_mvalid("single_wait", 80);
        chk("single_starts", 32'(starts - base), 32'd1);
        chk("single_m_data", 32'(m_data), 32'h3C);
        chk("single_tx_data", 32'(spi_tx_data), 32'hA5);
        chk("single_mvalid_lat", 32'(cyc - rx_cyc), 32'd1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(2);

        // burst fill with the host not reading
        resp_lat = 3;
        base = starts;
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        tick(40);
        chk("burst_rx_level", 32'(rx_level), 32'd4);
        chk("burst_tx_level", 32'(tx_level), 32'd2);
        chk("burst_starts", 32'(starts - base), 32'd4);
        chk("burst_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        n = 0;
        while (got.size() < 6 && n < 300) begin
            if (m_valid) got.push_back(m_data);
            tick(1);
            n++;
        end
        m_ready = 1'b0;
        if (got.size() < 6) fail_to("burst_drain");
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("burst_order", 32'(got[i]), 32'((8'h10 + 8'(i)) ^ KEY));
        got.delete();
        tick(5);

        // random traffic with coincident pushes, pops and completions
        resp_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    logic [7:0] w;
                    w = 8'($urandom);
                    sent.push_back(w);
                    push(w);
                    repeat ($urandom_range(0, 2)) tick(1);
                end
            end
            begin
                int k = 0;
                while (got.size() < 32 && k < 4000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    if (m_valid && m_ready) got.push_back(m_data);
                    tick(1);
                    k++;
                end
                m_ready = 1'b0;
            end
        join
        chk("rand_count", 32'(got.size()), 32'd32);
        for (int i = 0; i < 32 && i < got.size(); i++)
            chk("rand_order", 32'(got[i]), 32'(sent[i] ^ KEY));
        resp_rand = 1'b0;
        tick(5);

        // watchdog abort, recovery and flag clear
        resp_en = 1'b0;
        push(8'h77);
        wait_start("to_start", t0);
        n = 0;
        while (!timeout_err && n < TIMEOUT + 20) begin
            tick(1);
            n++;
        end
        if (!timeout_err) fail_to("to_wait");
        chk("to_latency", 32'(cyc - t0), 32'(TIMEOUT + 1));
        chk("to_rx_level", 32'(rx_level), 32'd0);
        resp_en = 1'b1;
        resp_lat = 4;
        push(8'h55);
        wait_mvalid("to_next", 40);
        chk("to_next_data", 32'(m_data), 32'hCC);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("to_cleared", 32'(timeout_err), 32'd0);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(3);

        // stray strobe while idle
        inj_data = 8'hEE;
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        tick(3);
        chk("stray_rx_level", 32'(rx_level), 32'd0);
        chk("stray_m_valid", 32'(m_valid), 32'd0);

        // reset mid-frame, then the late completion must be ignored
        resp_lat = 20;
        push(8'h42);
        wait_start("rst_start", t0);
        tick(5);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check_reset_vals("rst_wait");
        tick(30);
        chk("late_m_valid", 32'(m_valid), 32'd0);
        chk("late_rx_level", 32'(rx_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
